// File: rtl/hdmi_audio_pkg.sv
// Shared constants and types for HDMI audio sample packet decoding.
// Covers packet type, channel-status geometry and the layout of a decoded sample entry.
package hdmi_audio_pkg;

   localparam logic [7:0] AUDIO_SAMPLE_PACKET_TYPE = 8'd2;
   localparam int         CHANNEL_STATUS_LENGTH    = 192;
   localparam int         CS_CAPTURE_BITS          = 40;

   localparam int DATA_W  = 24;
   localparam int SUB_W   = 56;
   localparam int NUM_SUB = 4;
   localparam int FLAGS_W = 7;
   localparam int ENTRY_W = 2 * DATA_W + FLAGS_W;

   localparam int FLAG_VALID_L     = 0;
   localparam int FLAG_VALID_R     = 1;
   localparam int FLAG_USER_L      = 2;
   localparam int FLAG_USER_R      = 3;
   localparam int FLAG_PARITY_L    = 4;
   localparam int FLAG_PARITY_R    = 5;
   localparam int FLAG_BLOCK_START = 6;

   // Bit positions of the status byte inside one subpacket
   localparam int SB_V_L = 48;
   localparam int SB_U_L = 49;
   localparam int SB_C_L = 50;
   localparam int SB_P_L = 51;
   localparam int SB_V_R = 52;
   localparam int SB_U_R = 53;
   localparam int SB_P_R = 55;

   typedef enum logic {
      ST_IDLE,
      ST_UNPACK
   } unpack_state_t;

   typedef struct packed {
      logic [FLAGS_W-1:0] flags;
      logic [DATA_W-1:0]  right;
      logic [DATA_W-1:0]  left;
   } sample_entry_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// count includes the entry currently presented on rd_data.
module audio_sample_fifo #(
   parameter  int DATA_W = 55,
   parameter  int DEPTH  = 8,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  mem_cnt;
   logic              pop;
   logic              load;
   logic              from_mem;
   logic              bypass;
   logic              push;

   assign count = mem_cnt + CNT_W'(rd_valid);

   // An empty output stage takes a new write directly so the first word appears one edge after it is written
   always_comb begin
      pop      = rd_en & rd_valid;
      load     = ~rd_valid | pop;
      from_mem = load & (mem_cnt != '0);
      bypass   = load & (mem_cnt == '0) & wr_en;
      push     = wr_en & ~bypass & ((count != CNT_W'(DEPTH)) | pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (from_mem) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end else if (bypass) begin
            rd_data <= wr_data;
         end
         if (load) begin
            rd_valid <= from_mem | bypass;
         end
         mem_cnt <= mem_cnt + CNT_W'(push) - CNT_W'(from_mem);
      end
   end

endmodule

// File: rtl/audio_sample_packet_decoder.sv
// Unpacks HDMI audio sample packets into per-frame stereo entries, checks parity
// and rebuilds the left-channel status block across 192 frames.
module audio_sample_packet_decoder
   import hdmi_audio_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic         clk_pixel,
   input  logic         reset_n,
   input  logic         packet_valid,
   input  logic [23:0]  header,
   input  logic [223:0] sub,
   output logic         sample_valid,
   input  logic         sample_ready,
   output logic [23:0]  sample_left,
   output logic [23:0]  sample_right,
   output logic [6:0]   sample_flags,
   output logic [39:0]  channel_status,
   output logic         channel_status_valid,
   output logic         overflow,
   output logic         layout_error
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   unpack_state_t                      state;
   logic [1:0]                         sub_idx;
   logic [NUM_SUB-1:0]                 present_p0;
   logic [NUM_SUB-1:0]                 bstart_p0;
   logic [NUM_SUB*SUB_W-1:0]           sub_p0;
   sample_entry_t                      entry;
   sample_entry_t                      wr_data_p1;
   logic                               vld_p1;
   logic [7:0]                         frame_idx;
   logic [7:0]                         cur_idx;
   logic [7:0]                         next_idx;
   logic                               block_lock;
   logic [CS_CAPTURE_BITS-1:0]         shadow;
   logic [SUB_W-1:0]                   cur_sub;
   logic                               cur_bs;
   logic [CNT_W-1:0]                   fifo_count;
   logic [ENTRY_W-1:0]                 fifo_out;
   logic                               rd_fire;
   logic                               is_asp;
   logic                               fits;
   logic                               accept;
   int                                 post_count;
   logic                               unused_hdr;

   assign unused_hdr = ^header[19:13];

   function automatic logic parity_err(input logic [3:0] pcuv, input logic [DATA_W-1:0] word);
      return ^{pcuv, word};
   endfunction

   always_comb begin
      rd_fire    = sample_valid & sample_ready;
      is_asp     = packet_valid && (header[7:0] == AUDIO_SAMPLE_PACKET_TYPE);
      post_count = int'(fifo_count) + int'(vld_p1) - int'(rd_fire);
      fits       = (FIFO_DEPTH - post_count) >= $countones(header[11:8]);
      accept     = (state == ST_IDLE) && is_asp && !header[12] && fits;
   end

   always_comb begin
      cur_sub     = sub_p0[int'(sub_idx)*SUB_W +: SUB_W];
      cur_bs      = bstart_p0[sub_idx];
      cur_idx     = cur_bs ? 8'd0 : frame_idx;
      next_idx    = (cur_idx == 8'(CHANNEL_STATUS_LENGTH - 1)) ? 8'd0 : cur_idx + 8'd1;
      entry.left  = cur_sub[DATA_W-1:0];
      entry.right = cur_sub[2*DATA_W-1:DATA_W];
      entry.flags = '0;
      entry.flags[FLAG_VALID_L]     = cur_sub[SB_V_L];
      entry.flags[FLAG_VALID_R]     = cur_sub[SB_V_R];
      entry.flags[FLAG_USER_L]      = cur_sub[SB_U_L];
      entry.flags[FLAG_USER_R]      = cur_sub[SB_U_R];
      entry.flags[FLAG_PARITY_L]    = parity_err(cur_sub[SB_P_L:SB_V_L], cur_sub[DATA_W-1:0]);
      entry.flags[FLAG_PARITY_R]    = parity_err(cur_sub[SB_P_R:SB_V_R], cur_sub[2*DATA_W-1:DATA_W]);
      entry.flags[FLAG_BLOCK_START] = cur_bs;
   end

   // stage p0: packet capture
   always_ff @(posedge clk_pixel) begin
      if (accept) begin
         sub_p0 <= sub;
      end
   end

   // stage p1: one subpacket per cycle into the FIFO write register
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state                <= ST_IDLE;
         sub_idx              <= '0;
         present_p0           <= '0;
         bstart_p0            <= '0;
         vld_p1               <= 1'b0;
         wr_data_p1           <= '0;
         frame_idx            <= '0;
         block_lock           <= 1'b0;
         shadow               <= '0;
         channel_status       <= '0;
         channel_status_valid <= 1'b0;
         overflow             <= 1'b0;
         layout_error         <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (is_asp) begin
                  if (header[12]) begin
                     layout_error <= 1'b1;
                  end else if (!fits) begin
                     overflow <= 1'b1;
                  end else begin
                     present_p0 <= header[11:8];
                     bstart_p0  <= header[23:20];
                     sub_idx    <= '0;
                     state      <= ST_UNPACK;
                  end
               end
            end
            ST_UNPACK: begin
               if (is_asp) begin
                  overflow <= 1'b1;
               end
               if (present_p0[sub_idx]) begin
                  vld_p1     <= 1'b1;
                  wr_data_p1 <= entry;
                  frame_idx  <= next_idx;
                  block_lock <= block_lock | cur_bs;
                  if (cur_bs && (frame_idx != 8'd0)) begin
                     channel_status_valid <= 1'b0;
                  end
                  if (cur_idx < 8'(CS_CAPTURE_BITS)) begin
                     shadow[cur_idx[5:0]] <= cur_sub[SB_C_L];
                  end
                  if ((cur_idx == 8'(CHANNEL_STATUS_LENGTH - 1)) && block_lock) begin
                     channel_status       <= shadow;
                     channel_status_valid <= 1'b1;
                  end
               end
               sub_idx <= sub_idx + 2'd1;
               if (sub_idx == 2'd3) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // stage p2: FIFO output register
   audio_sample_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk_pixel),
      .reset_n  (reset_n),
      .wr_en    (vld_p1),
      .wr_data  (wr_data_p1),
      .rd_en    (sample_ready),
      .rd_valid (sample_valid),
      .rd_data  (fifo_out),
      .count    (fifo_count)
   );

   assign {sample_flags, sample_right, sample_left} = fifo_out;

endmodule
